// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter: 8-way round-robin arbiter with break-before-make and a split 3-to-8 grant decode.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_decoder_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int RR_START = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d, idx_q, idx_d;
    logic       valid_q, valid_d, to_q, to_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] rot;
    logic [2:0] off, win;
    logic [3:0] lane;
    logic       own_req, forced, rel;
    // Rotate so the pointer position becomes bit 0; the lowest set bit is the winner offset.
    always_comb begin
        rot = 8'({req, req} >> ptr_q);
        off = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (rot[i]) off = 3'(i);
        win = ptr_q + off;
    end
    assign own_req = req[idx_q];
    assign forced  = TO_EN && own_req && !done && hold_q == HOLD_LIM;
    assign rel     = done || !own_req || forced;
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        to_d    = 1'b0;
        if (state_q == GRANT) begin
            if (rel) begin
                valid_d = 1'b0;
                to_d    = forced;
                state_d = GAP;
            end else begin
                hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
            end
        end else if (|req) begin
            idx_d   = win;
            ptr_d   = win + 3'd1;
            valid_d = 1'b1;
            hold_d  = 8'd0;
            state_d = GRANT;
        end else begin
            valid_d = 1'b0;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'(RR_START);
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            hold_q  <= 8'd0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
        end
    end
    // idx[2] selects the half, idx[1:0] the line within it.
    assign lane        = 4'b0001 << idx_q[1:0];
    assign grant       = valid_q ? (idx_q[2] ? {lane, 4'b0000} : {4'b0000, lane}) : 8'h00;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;
    assign timeout     = to_q;
endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// tb_rr_decoder_arbiter: directed self-checking bench for rr_decoder_arbiter (MAX_HOLD=4).
module tb_rr_decoder_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;
    int         n_chk = 0;
    int         n_pass = 0;
    rr_decoder_arbiter #(.MAX_HOLD(4), .RR_START(0)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic owner(input string tag, input int idx);
        check({tag, "_valid"}, 32'(grant_valid), 32'd1);
        check({tag, "_idx"}, 32'(grant_idx), 32'(idx));
        check({tag, "_grant"}, 32'(grant), 32'(8'h01 << idx));
        check({tag, "_to"}, 32'(timeout), 32'd0);
    endtask
    task automatic idle(input string tag);
        check({tag, "_grant0"}, 32'(grant), 32'd0);
        check({tag, "_valid0"}, 32'(grant_valid), 32'd0);
    endtask
    initial begin
        rst_n = 1'b0; req = 8'hFF; done = 1'b0;
        step(); step();
        idle("rst");
        check("rst_idx", 32'(grant_idx), 32'd0);
        check("rst_to", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        step();
        owner("first", 0);
        for (int k = 1; k <= 8; k++) begin
            done = 1'b1;
            step();
            idle("rot_gap");
            done = 1'b0;
            step();
            owner("rot", k % 8);
        end
        req = 8'h04;
        step(); idle("drop0");
        step(); owner("to_ptr3", 2);
        req = 8'b1001_0100; done = 1'b1;
        step(); idle("sp_gap1");
        done = 1'b0;
        step(); owner("sp4", 4);
        done = 1'b1; step(); idle("sp_gap2");
        done = 1'b0; step(); owner("sp7", 7);
        done = 1'b1; step(); idle("sp_gap3");
        done = 1'b0; step(); owner("sp2", 2);
        req = 8'h20; done = 1'b1; step(); idle("o5_gap");
        done = 1'b0; step(); owner("o5", 5);
        req = 8'h00;
        step(); idle("rdrop_gap");
        step(); idle("rdrop_idle");
        check("idle_holds_idx", 32'(grant_idx), 32'd5);
        done = 1'b1; step(); idle("done_in_idle");
        done = 1'b0;
        req = 8'h01;
        step(); owner("hold0", 0);
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k < 4; k++) begin
            step(); owner("hold", 0);
        end
        step();
        idle("forced");
        check("timeout_pulse", 32'(timeout), 32'd1);
        step(); owner("regrant", 0);
`else
        for (int k = 1; k < 10; k++) begin
            step(); owner("hold", 0);
        end
`endif
        done = 1'b1; step(); idle("pre_mid");
        done = 1'b0; req = 8'h40;
        step(); owner("mid6", 6);
        rst_n = 1'b0;
        step(); idle("mid_rst");
        check("mid_rst_idx", 32'(grant_idx), 32'd0);
        rst_n = 1'b1;
        step(); owner("post6", 6);
        rst_n = 1'b0; step();
        rst_n = 1'b1; req = 8'hFF;
        step(); owner("ptr_reset", 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
